// File: rtl/level_meter_peak.sv
// Stereo level meter with per-channel peak hold/decay and thermometer bar output.
// Pipeline: stage 1 registers |sample|, stage 2 registers level, peak and bar.
//
// Peak tracker states (implied by the counters):
//   state | meaning
//   IDLE  | peak = 0 and level = 0, counters frozen
//   HOLD  | hold > 0, peak held, hold counts down per sample
//   DECAY | hold = 0, peak drops one bin every DECAY_SAMPLES samples
module level_meter_peak #(
  parameter  int SAMPLE_W      = 32,
  parameter  int NUM_BINS      = 10,
  parameter  int STEP          = 3,
  parameter  int HOLD_SAMPLES  = 4800,
  parameter  int DECAY_SAMPLES = 480,
  localparam int LW            = $clog2(NUM_BINS + 1)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic [1:0]          mode,
  input  logic                peak_en,
  input  logic                clip_clr,
  output logic [LW-1:0]       level_l,
  output logic [LW-1:0]       level_r,
  output logic [LW-1:0]       peak_l,
  output logic [LW-1:0]       peak_r,
  output logic                clip_l,
  output logic                clip_r,
  output logic [NUM_BINS-1:0] bar,
  output logic                bar_valid
);

  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int DW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam logic [SAMPLE_W-1:0] FULL_SCALE = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MOST_NEG   = {1'b1, {(SAMPLE_W-1){1'b0}}};

  if ((SAMPLE_W - 2 - STEP * (NUM_BINS - 1)) < 0 || HOLD_SAMPLES < 1 || DECAY_SAMPLES < 1)
  begin : g_bad_params
    $error("level_meter_peak: illegal parameter combination");
  end

  typedef struct packed {
    logic [LW-1:0] peak;
    logic [HW-1:0] hold;
    logic [DW-1:0] decay;
  } pk_t;

  // Magnitude with the most-negative code saturated to full scale.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1])     return x;
    else if (x == MOST_NEG) return FULL_SCALE;
    else                    return ~x + SAMPLE_W'(1);
  endfunction

  // Number of thresholds met; thresholds are powers of two spaced STEP bits apart.
  function automatic logic [LW-1:0] to_level(input logic [SAMPLE_W-1:0] a);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BINS; i++)
      if (a >= (SAMPLE_W'(1) << (SAMPLE_W - 2 - STEP * (NUM_BINS - 1 - i))))
        n = LW'(i + 1);
    return n;
  endfunction

  // One sample step of the peak tracker.
  function automatic pk_t peak_step(input pk_t s, input logic [LW-1:0] lvl);
    pk_t n;
    n = s;
    if (s.peak != '0 || lvl != '0) begin
      if (lvl >= s.peak) begin
        n.peak  = lvl;
        n.hold  = HW'(HOLD_SAMPLES);
        n.decay = '0;
      end else if (s.hold != '0) begin
        n.hold = s.hold - 1'b1;
      end else if (s.decay == DW'(DECAY_SAMPLES - 1)) begin
        // lvl < peak here, so peak-1 can never undershoot the level
        n.decay = '0;
        n.peak  = s.peak - 1'b1;
      end else begin
        n.decay = s.decay + 1'b1;
      end
    end
    return n;
  endfunction

  logic [SAMPLE_W-1:0] abs_in_l, abs_in_r, abs_l, abs_r;
  logic                v1;
  logic [LW-1:0]       lvl_nxt_l, lvl_nxt_r, sel_lvl, sel_pk;
  pk_t                 st_l, st_r, st_nxt_l, st_nxt_r;
  logic [NUM_BINS-1:0] bar_nxt;

  assign abs_in_l  = abs_sat(left_in);
  assign abs_in_r  = abs_sat(right_in);
  assign lvl_nxt_l = to_level(abs_l);
  assign lvl_nxt_r = to_level(abs_r);
  assign st_nxt_l  = peak_step(st_l, lvl_nxt_l);
  assign st_nxt_r  = peak_step(st_r, lvl_nxt_r);
  assign peak_l    = st_l.peak;
  assign peak_r    = st_r.peak;

  // Stage 1: capture channel magnitudes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      abs_l <= '0;
      abs_r <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) begin
        abs_l <= abs_in_l;
        abs_r <= abs_in_r;
      end
    end
  end

  // Sticky clip flags; a new clip beats a simultaneous clear.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
    end else begin
      if (sample_valid && abs_in_l >= FULL_SCALE) clip_l <= 1'b1;
      else if (clip_clr)                          clip_l <= 1'b0;
      if (sample_valid && abs_in_r >= FULL_SCALE) clip_r <= 1'b1;
      else if (clip_clr)                          clip_r <= 1'b0;
    end
  end

  // Select bar source and build the thermometer plus peak dot.
  always_comb begin
    sel_lvl = lvl_nxt_l;
    sel_pk  = st_nxt_l.peak;
    case (mode)
      2'd0: begin
        sel_lvl = lvl_nxt_l;
        sel_pk  = st_nxt_l.peak;
      end
      2'd1: begin
        sel_lvl = lvl_nxt_r;
        sel_pk  = st_nxt_r.peak;
      end
      default: begin
        sel_lvl = (lvl_nxt_l > lvl_nxt_r) ? lvl_nxt_l : lvl_nxt_r;
        sel_pk  = (st_nxt_l.peak > st_nxt_r.peak) ? st_nxt_l.peak : st_nxt_r.peak;
      end
    endcase
    bar_nxt = '0;
    for (int k = 0; k < NUM_BINS; k++)
      bar_nxt[k] = (LW'(k) < sel_lvl) || (peak_en && sel_pk == LW'(k + 1));
  end

  // Stage 2: levels, peak trackers and bar update together on stage-1 valid.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      level_l   <= '0;
      level_r   <= '0;
      st_l      <= '0;
      st_r      <= '0;
      bar       <= '0;
      bar_valid <= 1'b0;
    end else begin
      bar_valid <= v1;
      if (v1) begin
        level_l <= lvl_nxt_l;
        level_r <= lvl_nxt_r;
        st_l    <= st_nxt_l;
        st_r    <= st_nxt_r;
        bar     <= bar_nxt;
      end
    end
  end

endmodule

// File: tb/tb_level_meter_peak.sv
// Scoreboard bench for level_meter_peak: expected outputs are modelled at drive
// time, queued, and compared when bar_valid appears.
module tb_level_meter_peak;

  localparam int W = 32, NB = 10, ST = 3, HOLD = 4, DEC = 2;

  logic               CLOCK_50 = 1'b0;
  logic               reset = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [31:0] left_in = '0, right_in = '0;
  logic [1:0]         mode = 2'd0;
  logic               peak_en = 1'b0, clip_clr = 1'b0;
  logic [3:0]         level_l, level_r, peak_l, peak_r;
  logic               clip_l, clip_r, bar_valid;
  logic [9:0]         bar;

  level_meter_peak #(
    .SAMPLE_W(W), .NUM_BINS(NB), .STEP(ST), .HOLD_SAMPLES(HOLD), .DECAY_SAMPLES(DEC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid),
    .left_in(left_in), .right_in(right_in), .mode(mode), .peak_en(peak_en),
    .clip_clr(clip_clr), .level_l(level_l), .level_r(level_r), .peak_l(peak_l),
    .peak_r(peak_r), .clip_l(clip_l), .clip_r(clip_r), .bar(bar), .bar_valid(bar_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int         cyc;
    int         ll, lr, pl, pr;
    logic [9:0] bar;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   pk[2] = '{0, 0}, hd[2] = '{0, 0}, dc[2] = '{0, 0};

  int exp_pk[16]  = '{5, 5, 5, 5, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0, 0};
  int exp_bar[16] = '{'h1F, 'h10, 'h10, 'h10, 'h10, 'h10, 'h08, 'h08,
                      'h04, 'h04, 'h02, 'h02, 'h01, 'h01, 'h00, 'h00};

  // Level from the threshold ladder 8, 64, 512, ... 2^30.
  function automatic int lvl_of(input logic signed [31:0] x);
    longint a;
    int     n;
    a = x;
    if (a < 0) a = -a;
    if (a > 64'h7FFF_FFFF) a = 64'h7FFF_FFFF;
    n = 0;
    for (int i = 0; i < NB; i++)
      if (a >= (longint'(1) << (3 + 3 * i))) n = i + 1;
    return n;
  endfunction

  task automatic model_peak(input int ch, input int lv);
    if (pk[ch] == 0 && lv == 0) return;
    if (lv >= pk[ch]) begin
      pk[ch] = lv; hd[ch] = HOLD; dc[ch] = 0;
    end else if (hd[ch] > 0) begin
      hd[ch]--;
    end else if (dc[ch] == DEC - 1) begin
      dc[ch] = 0;
      pk[ch] = (pk[ch] - 1 > lv) ? pk[ch] - 1 : lv;
    end else begin
      dc[ch]++;
    end
  endtask

  task automatic send(input logic signed [31:0] l, input logic signed [31:0] r,
                      input bit track = 1'b1);
    exp_t e;
    int   lsel, psel;
    left_in = l; right_in = r; sample_valid = 1'b1;
    if (track) begin
      e.ll = lvl_of(l);
      e.lr = lvl_of(r);
      model_peak(0, e.ll);
      model_peak(1, e.lr);
      e.pl = pk[0];
      e.pr = pk[1];
      case (mode)
        2'd0:    begin lsel = e.ll; psel = e.pl; end
        2'd1:    begin lsel = e.lr; psel = e.pr; end
        default: begin
          lsel = (e.ll > e.lr) ? e.ll : e.lr;
          psel = (e.pl > e.pr) ? e.pl : e.pr;
        end
      endcase
      e.bar = 10'((1 << lsel) - 1);
      if (peak_en && psel > 0) e.bar[psel-1] = 1'b1;
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    clip_clr     = 1'b0;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      pk[c] = 0; hd[c] = 0; dc[c] = 0;
    end
  endtask

  task automatic do_reset(input int n);
    sample_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (n) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level_l"}, level_l, 0);
    chk({tag, "_level_r"}, level_r, 0);
    chk({tag, "_peak_l"}, peak_l, 0);
    chk({tag, "_peak_r"}, peak_r, 0);
    chk({tag, "_clip_l"}, clip_l, 0);
    chk({tag, "_clip_r"}, clip_r, 0);
    chk({tag, "_bar"}, bar, 0);
    chk({tag, "_bar_valid"}, bar_valid, 0);
  endtask

  // Scoreboard consumer: every bar_valid must match the oldest queued expectation.
  always @(negedge CLOCK_50) begin
    if (bar_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_bar_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("sb_cycle", cyc, mon_e.cyc);
        chk("sb_level_l", level_l, mon_e.ll);
        chk("sb_level_r", level_r, mon_e.lr);
        chk("sb_peak_l", peak_l, mon_e.pl);
        chk("sb_peak_r", peak_r, mon_e.pr);
        chk("sb_bar", bar, mon_e.bar);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic signed [31:0] rl, rr;

    repeat (2) @(negedge CLOCK_50);
    chk_zero("in_reset");
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Basic levels and full-scale clip
    mode = 2'd0; peak_en = 1'b1;
    send(32'sd9, 32'sd0);
    send(32'sd7, 32'sd0);
    send(32'sh8000_0000, 32'sd0);
    chk("clip_l_set", clip_l, 1);
    chk("clip_r_quiet", clip_r, 0);
    idle(2);
    chk("full_level_l", level_l, 10);
    chk("full_bar", bar, 10'h3FF);

    // Peak hold then stepwise decay
    do_reset(2);
    peak_en = 1'b1; mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      send((i == 0) ? 32'sd32768 : 32'sd0, 32'sd0);
      idle(1);
      chk("hold_peak_l", peak_l, exp_pk[i]);
      chk("hold_bar", bar, exp_bar[i]);
    end

    // Back-to-back samples
    idle(2);
    for (int k = 0; k < 8; k++) begin
      rl = $signed($urandom) >>> $urandom_range(0, 30);
      rr = $signed($urandom) >>> $urandom_range(0, 30);
      send(rl, rr);
    end
    idle(4);

    // Mode selection and deferred effect of mode changes
    do_reset(2);
    peak_en = 1'b0; mode = 2'd2;
    send(32'sd512, 32'sd2097152);
    idle(2);
    chk("mode2_bar", bar, 10'h07F);
    mode = 2'd0;
    idle(3);
    chk("mode_change_no_update", bar, 10'h07F);
    send(32'sd512, 32'sd2097152);
    idle(2);
    chk("mode0_bar", bar, 10'h007);
    mode = 2'd1;
    send(32'sd512, 32'sd2097152);
    idle(2);
    chk("mode1_bar", bar, 10'h07F);
    mode = 2'd3; peak_en = 1'b1;
    send(32'sd0, 32'sd0);
    idle(2);
    chk("mode3_peak_dot", bar, 10'h040);

    // Clip set wins over same-cycle clear; clear alone then clears
    clip_clr = 1'b1;
    send(32'sh8000_0000, 32'sd0);
    chk("clip_set_wins", clip_l, 1);
    sample_valid = 1'b0;
    @(negedge CLOCK_50);
    clip_clr = 1'b0;
    chk("clip_cleared", clip_l, 0);
    idle(3);

    // Reset while a sample is in flight
    send(32'sd32768, 32'sd32768, 1'b0);
    sample_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge CLOCK_50);
    chk_zero("flight_reset");
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    chk_zero("after_reset");

    // First sample after reset processes normally
    mode = 2'd2;
    send(-32'sd9, 32'sh4000_0000);
    idle(2);
    chk("post_reset_level_l", level_l, 1);
    chk("post_reset_level_r", level_r, 10);

    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge CLOCK_50);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/level_meter_peak.md
LEVEL_METER_PEAK -- requirements
Module: level_meter_peak

Interface
REQ-001 The module SHALL have the parameter SAMPLE_W, default 32, meaning the signed two's-complement sample width.
REQ-002 The module SHALL have the parameter NUM_BINS, default 10, meaning the number of meter segments.
REQ-003 The module SHALL have the parameter STEP, default 3, meaning the shift distance between adjacent bin thresholds (about 18 dB).
REQ-004 The module SHALL have the parameter HOLD_SAMPLES, default 4800, meaning the number of valid samples for which the peak is held (0.1 s at 48 kHz).
REQ-005 The module SHALL have the parameter DECAY_SAMPLES, default 480, meaning the number of valid samples per one-bin peak decay step.
REQ-006 CLOCK_50  in  1  system clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 sample_valid  in  1  one-cycle strobe qualifying left_in and right_in; it SHALL be legal on every cycle.
REQ-009 left_in, right_in  in  SAMPLE_W  signed audio samples.
REQ-010 mode  in  2  bar source: 0 = left, 1 = right, 2 or 3 = max(left, right).
REQ-011 peak_en  in  1  when high, the peak-dot segment SHALL be overlaid on bar.
REQ-012 clip_clr  in  1  one-cycle strobe that clears both clip flags.
REQ-013 level_l, level_r  out  LW = $clog2(NUM_BINS+1)  instantaneous level per channel, range 0..NUM_BINS.
REQ-014 peak_l, peak_r  out  LW  held/decaying peak level per channel.
REQ-015 clip_l, clip_r  out  1  sticky clip flags.
REQ-016 bar  out  NUM_BINS  thermometer bar for direct LED drive; bit 0 is the lowest segment.
REQ-017 bar_valid  out  1  one-cycle pulse issued whenever the level, peak and bar outputs update.

Function
REQ-018 Elaboration SHALL fail unless SAMPLE_W-2-STEP*(NUM_BINS-1) >= 0, HOLD_SAMPLES >= 1 and DECAY_SAMPLES >= 1.
REQ-019 Stage 1 (the edge on which sample_valid is high) SHALL register the absolute value of each channel; the most-negative input SHALL saturate to 2^(SAMPLE_W-1)-1.
REQ-020 Bin threshold T_i (i = 0..NUM_BINS-1) SHALL equal 2^(SAMPLE_W-2-STEP*(NUM_BINS-1-i)); with the defaults, T_0 = 8 and T_9 = 2^30.
REQ-021 Stage 2 SHALL register level = the count of thresholds satisfying abs >= T_i; thresholds are monotonic, so the count equals the index of the highest satisfied threshold plus 1.
REQ-022 level_*, peak_*, bar and bar_valid SHALL update exactly 2 cycles after the sample_valid cycle; back-to-back samples SHALL produce back-to-back bar_valid pulses with no sample dropped.
REQ-023 Peak state per channel SHALL be a peak register, a hold counter and a decay counter, all advanced only on stage-2 valid.
REQ-024 In HOLD state (hold counter > 0), if level >= peak then peak <= level and hold <= HOLD_SAMPLES; otherwise hold decrements by 1.
REQ-025 In DECAY state (hold counter = 0), if level >= peak then peak <= level, hold <= HOLD_SAMPLES and decay <= 0.
REQ-026 In DECAY state with level < peak, the decay counter SHALL increment; when it reaches DECAY_SAMPLES-1 it SHALL wrap to 0 and peak SHALL decrement by 1, never below the current level.
REQ-027 When peak equals 0 and level equals 0, the peak state SHALL remain idle with no counter activity.
REQ-028 clip_* SHALL set on a stage-1 abs >= 2^(SAMPLE_W-1)-1 and SHALL hold until clip_clr; if set and clear occur in the same cycle, set SHALL win.
REQ-029 The selected level L and peak P SHALL come from mode; for modes 2 and 3, L = max(level_l, level_r) and P = max(peak_l, peak_r).
REQ-030 bar[k] SHALL be high for k < L; if peak_en is high and P > 0, bar[P-1] SHALL also be high.
REQ-031 A change on mode or peak_en SHALL affect bar only at the next bar_valid update.

Reset
REQ-032 While reset is high, all outputs, pipeline registers and counters SHALL be 0, including bar_valid.
REQ-033 Samples in flight when reset asserts SHALL be discarded, and no bar_valid SHALL issue for them after release.
REQ-034 The first sample_valid after reset release SHALL be processed normally.

Verification
REQ-035 Defaults, left_in = 9, then 7, then -2^31 -> level_l = 1 then 0 then 10, clip_l = 1, bar = 10'h3FF.
REQ-036 HOLD_SAMPLES = 4, DECAY_SAMPLES = 2, one sample at level 5 then zeros with peak_en = 1 -> peak_l stays 5 for 4 samples, then falls 4, 3, 2, 1, 0 every 2 samples, and bar = 10'h010 during the hold.
REQ-037 sample_valid high for 8 consecutive cycles -> 8 consecutive bar_valid pulses beginning 2 cycles later, with values matching input order.
REQ-038 mode = 2, left at level 3 and right at level 7 -> bar = 10'h07F; switching to mode = 0 gives bar = 10'h007 after the next update.
REQ-039 clip_clr in the same cycle as a new clipping sample reaches stage 1 -> clip_l remains 1; clip_clr alone one cycle later -> clip_l = 0.
REQ-040 reset pulse on the cycle after sample_valid -> no bar_valid, and all outputs are 0 on the following cycles.
